// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared widths, types and parameter checks for the FIFO read-stream adapter.
package fifo_rd_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int MAX_RD_LATENCY     = 2;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_word_t;

    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Every outstanding read must have a slot waiting for it, plus the head being presented.
    function automatic bit buf_depth_ok(input int depth, input int rd_latency);
        return depth >= rd_latency + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_skid_buf.sv
// Circular register skid buffer with push/pop, occupancy count and head-of-queue output.
module skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3
) (
    input  logic                          i_clk,
    input  logic                          i_s_rst,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_pop,
    output logic [count_width(DEPTH)-1:0] o_count,
    output logic [DATA_WIDTH-1:0]         o_head,
    output logic                          o_dropped
);

    localparam int            PW       = ptr_width(DEPTH);
    localparam int            CW       = count_width(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_do_pop = i_pop && !w_empty;
    // A pop frees the head slot on the same edge, so a push is still accepted when full.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_dropped = i_push && !w_do_push;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a fixed-latency FIFO read port into a valid/ready stream master.
// Optional packet framing on o_m_tlast is enabled by defining FIFO_RD_STREAM_TLAST_EN.
module fifo_rd_stream_adapter
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 3,
    parameter int PKT_LEN    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_s_rst,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic                  i_fifo_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic                  o_m_tlast,
    output logic                  o_ovf_err,
    output logic                  o_unexp_err
);

    localparam int CW = count_width(BUF_DEPTH);
    localparam int IW = count_width(RD_LATENCY);

    if (!buf_depth_ok(BUF_DEPTH, RD_LATENCY)) begin : g_bad_depth
        $error("fifo_rd_stream_adapter: BUF_DEPTH must be at least RD_LATENCY+1");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("fifo_rd_stream_adapter: RD_LATENCY must be 1 or 2");
    end
    if (PKT_LEN < 1) begin : g_bad_pkt_len
        $error("fifo_rd_stream_adapter: PKT_LEN must be at least 1");
    end

    logic [CW-1:0] w_count;
    logic          w_dropped;
    logic          w_pop;
    logic          w_rd_en;
    logic [IW-1:0] r_inflight;
    logic          r_ovf_err;
    logic          r_unexp_err;

    // Reads are issued only when a slot is guaranteed for the returning data; no tready path.
    assign w_rd_en = !i_s_rst && !i_fifo_empty
                     && ((int'(w_count) + int'(r_inflight)) < BUF_DEPTH);
    assign w_pop   = o_m_tvalid && i_m_tready;

    skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_skid_buf (
        .i_clk     (i_clk),
        .i_s_rst   (i_s_rst),
        .i_push    (i_fifo_rd_valid),
        .i_data    (i_fifo_rd_data),
        .i_pop     (w_pop),
        .o_count   (w_count),
        .o_head    (o_m_tdata),
        .o_dropped (w_dropped)
    );

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_inflight  <= '0;
            r_ovf_err   <= 1'b0;
            r_unexp_err <= 1'b0;
        end else begin
            if (w_rd_en && !i_fifo_rd_valid) begin
                r_inflight <= r_inflight + IW'(1);
            end else if (!w_rd_en && i_fifo_rd_valid && (r_inflight != '0)) begin
                r_inflight <= r_inflight - IW'(1);
            end
            if (w_dropped) begin
                r_ovf_err <= 1'b1;
            end
            if (i_fifo_rd_valid && (r_inflight == '0)) begin
                r_unexp_err <= 1'b1;
            end
        end
    end

`ifdef FIFO_RD_STREAM_TLAST_EN
    localparam int BW = (PKT_LEN <= 1) ? 1 : $clog2(PKT_LEN);

    logic [BW-1:0] r_beat_cnt;
    logic          w_last_beat;

    assign w_last_beat = (r_beat_cnt == BW'(PKT_LEN - 1));

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + BW'(1);
        end
    end

    assign o_m_tlast = o_m_tvalid && w_last_beat;
`else
    assign o_m_tlast = 1'b0;
`endif

    assign o_fifo_rd_en = w_rd_en;
    assign o_m_tvalid   = (w_count != '0);
    assign o_ovf_err    = r_ovf_err;
    assign o_unexp_err  = r_unexp_err;

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
- Read-side master for sync_fifo. Drains the FIFO read port (rd_en / rd_valid / rd_data / empty) and presents it as a valid/ready stream master.
- Absorbs the FIFO's fixed read latency in a small internal skid buffer. No beat is lost or duplicated under arbitrary downstream back-pressure.
- Sits between sync_fifo and any stream consumer (DMA, packetiser, checker).

Parameters:
- DATA_WIDTH, 8, width of FIFO read data and stream data.
- RD_LATENCY, 1, cycles from i_fifo rd_en high to rd_valid high; legal values 1..2.
- BUF_DEPTH, 3, skid buffer entries. Must be >= RD_LATENCY+2 for full throughput and >= RD_LATENCY+1 for correctness (elaboration $error otherwise).
- PKT_LEN, 16, beats per packet; used only when FIFO_RD_STREAM_TLAST_EN is defined; >= 1.

Ports:
- i_clk  in  1  clock
- i_s_rst  in  1  synchronous reset, active-high
- i_fifo_empty  in  1  FIFO empty flag
- o_fifo_rd_en  out  1  FIFO read request
- i_fifo_rd_valid  in  1  FIFO read data valid
- i_fifo_rd_data  in  DATA_WIDTH  FIFO read data
- o_m_tvalid  out  1  stream valid
- i_m_tready  in  1  stream ready
- o_m_tdata  out  DATA_WIDTH  stream data
- o_m_tlast  out  1  packet end (tied 0 without macro)
- o_ovf_err  out  1  sticky: rd_valid arrived with buffer full
- o_unexp_err  out  1  sticky: rd_valid with no outstanding request

Behaviour:
- Clock and reset: single clock i_clk. i_s_rst is synchronous and active-high.
- Reset values:
  - o_m_tvalid=0, o_m_tdata=0, o_m_tlast=0, o_fifo_rd_en=0 (forced low during reset).
  - Both error flags 0, count=0, inflight=0, pointers=0.
- Skid buffer: circular, BUF_DEPTH entries, wr_ptr/rd_ptr wrap modulo BUF_DEPTH (non-power-of-2 allowed; explicit compare-and-clear), count 0..BUF_DEPTH.
- inflight: number of issued reads whose rd_valid has not yet returned, 0..RD_LATENCY. Increments on o_fifo_rd_en, decrements on i_fifo_rd_valid; both in the same cycle leaves it unchanged.
- Issue rule: o_fifo_rd_en = !i_s_rst && !i_fifo_empty && (count + inflight) < BUF_DEPTH.
  - Depends only on registered state and i_fifo_empty. No combinational path from i_m_tready.
- Push: on i_fifo_rd_valid, write i_fifo_rd_data at wr_ptr.
  - If count==BUF_DEPTH and no pop this cycle: drop the data and set o_ovf_err.
  - If inflight==0: set o_unexp_err and still push if space.
- Pop: when o_m_tvalid && i_m_tready, advance rd_ptr.
- Simultaneous push and pop: count unchanged; legal at count==BUF_DEPTH.
- Output:
  - o_m_tvalid = (count != 0).
  - o_m_tdata = buf[rd_ptr], registered storage with mux output.
  - tdata is stable while tvalid && !tready (AXI-S rule).
- Latency: first beat is visible on o_m_tvalid RD_LATENCY+1 cycles after the first o_fifo_rd_en.
- Throughput: with the default parameters and tready=1, one beat per cycle once primed.
- Reset mid-operation:
  - All state is cleared and in-flight returns are discarded.
  - rd_valid in the cycle after reset deassertion is flagged by o_unexp_err. The FIFO is reset together with this block, so this does not occur in normal operation.
- Error flags: sticky until reset.

Optional Feature:
- Macro: FIFO_RD_STREAM_TLAST_EN.
- Defined:
  - A beat counter 0..PKT_LEN-1 advances on each pop.
  - o_m_tlast=1 when counter==PKT_LEN-1 and tvalid; the counter wraps to 0 on that pop.
  - The counter is reset by i_s_rst.
- Undefined: no counter logic; o_m_tlast tied to 0.

Decomposition:
- Package fifo_rd_stream_pkg:
  - function clog2-based ptr/count widths (count width = $clog2(BUF_DEPTH+1)).
  - typedef for data word.
  - localparam minimum BUF_DEPTH check expression.
- One natural sub-module: skid_buf.
  - Circular register buffer with push/pop/count/head.
  - Reusable for other read-latency adapters.
- Issue logic, inflight counter, errors and tlast stay in the top.

Test Plan:
- Reset then continuous drain:
  - Stimulus: preload sync_fifo with 0x00..0x07, tready=1.
  - Response: first tvalid 2 cycles after the first rd_en; then 8 consecutive beats 0x00..0x07 with no gaps; rd_en deasserts when empty; errors 0.
- Back-pressure:
  - Stimulus: 8 words, tready held 0 for 10 cycles.
  - Response: rd_en stops after 3 issues; count=3; tdata=0x00 stable; after tready=1, all 8 beats delivered in order.
- Random stress:
  - Stimulus: random_state_generator pairs drive writer wr_en and tready; 100k cycles; scoreboard compares against the written sequence.
  - Response: zero mismatches; o_ovf_err=o_unexp_err=0.
- Simultaneous push/pop at full:
  - Stimulus: count=3, tready pulses 1 for one cycle while rd_valid=1.
  - Response: count stays 3; no overflow; order preserved.
- Reset mid-stream:
  - Stimulus: i_s_rst asserted 1 cycle while inflight=1 and count=2.
  - Response: next cycle tvalid=0, rd_en=0, count=0; errors 0.
- TLAST (macro on, PKT_LEN=4):
  - Stimulus: 12 beats streamed.
  - Response: tlast=1 on beats 3, 7 and 11 only.
